ram_sdp_clr: RTL and testbench

- Parametrised simple-dual-port RAM: one write port and one independent read port on a single clock.
- Successor to the 8x64K sync-write/async-read RAM. Generalises data and address width.
- Adds a selectable read mode (async or registered), read-during-write policy, read-valid flag, and a hardware clear engine that fills the array with CLR_VAL after reset or on request.
- Used as the generic storage macro under FIFOs, line buffers and register files.

---
 rtl/ram_sdp_clr_pkg.sv | 19 +
 rtl/ram_clr_fsm.sv | 68 ++++++
 rtl/ram_sdp_clr.sv | 150 +++++++++++++++
 tb/tb_ram_sdp_clr.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sdp_clr_pkg.sv
// Shared definitions for the ram_sdp_clr storage macro: clear-engine state
// encoding and the symbolic values of the read-mode parameters.
package ram_pkg;

  // Clear-engine states. ST_CLEAR doubles as the busy indication.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // RD_MODE values
  localparam int RD_ASYNC = 0;
  localparam int RD_SYNC  = 1;

  // RDW_MODE values (same-address read and write on one edge, RD_MODE = RD_SYNC)
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine for ram_sdp_clr. Owns the IDLE/CLEAR state, the clear
// counter and the single write port into the array: while clearing, the port
// walks every address writing CLR_WORD; otherwise it carries the user write.
//
// Handshake: there is no backpressure. o_state == ST_CLEAR means the array
// belongs to the clear engine and any user write presented is discarded; the
// caller must treat that cycle's request as lost, not queued.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                MEM_W    = 8,
  parameter logic [MEM_W-1:0]  CLR_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_e,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MEM_W-1:0]  w_word,
  output state_t            o_state,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [MEM_W-1:0]  o_mem_word
);

  // Last address to clear; the counter carries one spare bit so the terminal
  // compare never aliases with address 0.
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t          r_state;
  logic [ADDR_W:0] r_cnt;

  // State and counter: reset or clr (re)starts a sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (clr) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_cnt == LAST) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Write-port mux: clear sweep has priority; a user write loses to clr.
  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_addr = w_addr;
    o_mem_word = w_word;
    if (r_state == ST_CLEAR) begin
      o_mem_we   = 1'b1;
      o_mem_addr = r_cnt[ADDR_W-1:0];
      o_mem_word = CLR_WORD;
    end else if (w_e && !clr) begin
      o_mem_we = 1'b1;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ram_sdp_clr.sv
// Parametrised simple-dual-port RAM with hardware clear engine.
// One write port, one read port, single clock. Read is combinational
// (RD_MODE = RD_ASYNC) or registered with one cycle latency (RD_MODE = RD_SYNC);
// RDW_MODE picks old or new data for a same-address read/write in sync mode.
// After reset, or on a clr pulse, every word is filled with CLR_VAL over
// DEPTH cycles while busy is high; user traffic is ignored meanwhile.
//
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per word,
// add the err_inj input (store inverted parity) and the perr output (parity
// mismatch on a valid read, timed like r_valid).
//
// Read handshake: r_valid is the only qualifier for dout. No ready/backpressure
// exists; a read request (r_e) made while busy is dropped and yields r_valid=0.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 16,
  parameter int                 RD_MODE  = 0,
  parameter int                 RDW_MODE = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_e,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] data,
  input  logic              r_e,
  input  logic [ADDR_W-1:0] r_addr,
`ifdef RAM_PARITY_EN
  input  logic              err_inj,
  output logic              perr,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              r_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef RAM_PARITY_EN
  // Word layout: {data, parity}; parity makes the XOR of the whole word zero.
  localparam int               MEM_W    = DATA_W + 1;
  localparam logic [MEM_W-1:0] CLR_WORD = {CLR_VAL, ^CLR_VAL};
`else
  localparam int               MEM_W    = DATA_W;
  localparam logic [MEM_W-1:0] CLR_WORD = CLR_VAL;
`endif

  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [MEM_W-1:0]  w_mem_word;
  logic              w_busy;
  state_t            w_state;

`ifdef RAM_PARITY_EN
  assign w_wr_word = {data, (^data) ^ err_inj};
`else
  assign w_wr_word = data;
`endif

  ram_clr_fsm #(
    .ADDR_W   (ADDR_W),
    .MEM_W    (MEM_W),
    .CLR_WORD (CLR_WORD)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .w_e        (w_e),
    .w_addr     (w_addr),
    .w_word     (w_wr_word),
    .o_state    (w_state),
    .o_mem_we   (w_mem_we),
    .o_mem_addr (w_mem_addr),
    .o_mem_word (w_mem_word)
  );

  assign w_busy = (w_state == ST_CLEAR);
  assign busy   = w_busy;

  // Array write: contents are deliberately not reset; the clear engine fills them.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_word;
    end
  end

  assign w_rd_word = r_mem[r_addr];

  generate
    if (RD_MODE == RD_SYNC) begin : g_sync
      logic [MEM_W-1:0]  w_sel_word;
      logic [DATA_W-1:0] r_dout;
      logic              r_rvalid;

      // Same-address forwarding: write-first returns the word being written.
      always_comb begin
        w_sel_word = w_rd_word;
        if ((RDW_MODE == RDW_WRITE_FIRST) && w_mem_we && (w_mem_addr == r_addr)) begin
          w_sel_word = w_mem_word;
        end
      end

      // Registered read: dout holds between accepted reads, r_valid pulses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dout   <= '0;
          r_rvalid <= 1'b0;
        end else if (r_e && !w_busy) begin
          r_dout   <= w_sel_word[MEM_W-1 -: DATA_W];
          r_rvalid <= 1'b1;
        end else begin
          r_rvalid <= 1'b0;
        end
      end

      assign dout    = r_dout;
      assign r_valid = r_rvalid;

`ifdef RAM_PARITY_EN
      logic r_perr;

      // Parity flag registered alongside r_valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_perr <= 1'b0;
        end else if (r_e && !w_busy) begin
          r_perr <= ^w_sel_word;
        end else begin
          r_perr <= 1'b0;
        end
      end

      assign perr = r_perr;
`endif
    end else begin : g_async
      assign dout    = w_rd_word[MEM_W-1 -: DATA_W];
      assign r_valid = r_e & ~w_busy;
`ifdef RAM_PARITY_EN
      assign perr    = r_valid & (^w_rd_word);
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: three instances (sync read-first, sync write-first,
// async read) share one directed stimulus stream. A behavioural model keeps
// the expected array contents and busy countdown; a compare process checks
// every cycle, and literal checks pin the model at key points.
module tb_ram_sdp_clr;

  localparam int         DW    = 8;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] CLRV  = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic          clr, w_e, r_e, err_inj;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] data;

  logic [DW-1:0] dout_rf, dout_wf, dout_as;
  logic          rv_rf, rv_wf, rv_as;
  logic          busy_rf, busy_wf, busy_as;
`ifdef RAM_PARITY_EN
  logic          perr_rf, perr_wf, perr_as;
`endif

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .RDW_MODE(0), .CLR_VAL(CLRV)) u_rf (
    .clk(clk), .rst(rst), .clr(clr), .w_e(w_e), .w_addr(w_addr), .data(data),
    .r_e(r_e), .r_addr(r_addr),
`ifdef RAM_PARITY_EN
    .err_inj(err_inj), .perr(perr_rf),
`endif
    .dout(dout_rf), .r_valid(rv_rf), .busy(busy_rf));

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .RDW_MODE(1), .CLR_VAL(CLRV)) u_wf (
    .clk(clk), .rst(rst), .clr(clr), .w_e(w_e), .w_addr(w_addr), .data(data),
    .r_e(r_e), .r_addr(r_addr),
`ifdef RAM_PARITY_EN
    .err_inj(err_inj), .perr(perr_wf),
`endif
    .dout(dout_wf), .r_valid(rv_wf), .busy(busy_wf));

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .RDW_MODE(0), .CLR_VAL(CLRV)) u_as (
    .clk(clk), .rst(rst), .clr(clr), .w_e(w_e), .w_addr(w_addr), .data(data),
    .r_e(r_e), .r_addr(r_addr),
`ifdef RAM_PARITY_EN
    .err_inj(err_inj), .perr(perr_as),
`endif
    .dout(dout_as), .r_valid(rv_as), .busy(busy_as));

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] exp_mem [DEPTH];
  logic          exp_err [DEPTH];
  logic [DW-1:0] exp_q [$];          // expected read data for the read-first instance
  logic          m_busy    = 1'b1;
  int            m_left    = DEPTH;  // clear edges still to come
  logic          m_sval    = 1'b0;
  logic [DW-1:0] m_dout_rf = '0;
  logic [DW-1:0] m_dout_wf = '0;
  logic          m_perr_rf = 1'b0;
  logic          m_perr_wf = 1'b0;
  logic          m_wr_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b1; m_left = DEPTH; m_sval = 1'b0;
      m_dout_rf = '0; m_dout_wf = '0; m_perr_rf = 1'b0; m_perr_wf = 1'b0;
      exp_q.delete();
    end else begin
      m_wr_ok = w_e && !clr && !m_busy;
      if (!m_busy && r_e) begin
        m_sval    = 1'b1;
        m_dout_rf = exp_mem[r_addr];
        m_perr_rf = exp_err[r_addr];
        exp_q.push_back(exp_mem[r_addr]);
        if (m_wr_ok && (w_addr == r_addr)) begin
          m_dout_wf = data;
          m_perr_wf = err_inj;
        end else begin
          m_dout_wf = exp_mem[r_addr];
          m_perr_wf = exp_err[r_addr];
        end
      end else begin
        m_sval = 1'b0; m_perr_rf = 1'b0; m_perr_wf = 1'b0;
      end
      if (m_busy) begin
        if (clr) m_left = DEPTH;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = CLRV; exp_err[i] = 1'b0; end
          end
        end
      end else if (clr) begin
        m_busy = 1'b1; m_left = DEPTH;
      end else if (m_wr_ok) begin
        exp_mem[w_addr] = data;
        exp_err[w_addr] = err_inj;
      end
    end
  end

  // ---------------- compare process (every cycle, #1 after the edge) ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        chk("busy_rf", busy_rf, m_busy);
        chk("busy_wf", busy_wf, m_busy);
        chk("busy_as", busy_as, m_busy);
        chk("rv_rf", rv_rf, m_sval);
        chk("rv_wf", rv_wf, m_sval);
        chk("dout_rf", dout_rf, m_dout_rf);
        chk("dout_wf", dout_wf, m_dout_wf);
        chk("rv_as", rv_as, r_e & ~m_busy);
        if (r_e && !m_busy) chk("dout_as", dout_as, exp_mem[r_addr]);
        if (rv_rf) begin
          if (exp_q.size() == 0) chk("rf_q_empty", 1, 0);
          else chk("rf_q", dout_rf, exp_q.pop_front());
        end
`ifdef RAM_PARITY_EN
        chk("perr_rf", perr_rf, m_perr_rf);
        chk("perr_wf", perr_wf, m_perr_wf);
        chk("perr_as", perr_as, (r_e && !m_busy) ? exp_err[r_addr] : 1'b0);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic c);
    @(negedge clk);
    w_e = we; w_addr = wa; data = d; r_e = re; r_addr = ra; clr = c; err_inj = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Counts edges until busy drops (bounded) and checks the clear length.
  task automatic wait_clear(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy_rf && n < 64);
    chk(name, n, DEPTH);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; w_e = 1'b0; r_e = 1'b0; err_inj = 1'b0;
    w_addr = '0; r_addr = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_rf, 1);
    chk("rst_rv", rv_rf, 0);
    chk("rst_dout", dout_rf, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    wait_clear("clr_len_rst");

    // every word reads CLR_VAL, r_valid one cycle after r_e
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(a), 1'b0); step();
      chk("rd_clr_val", dout_rf, 8'hA5);
      chk("rd_clr_vld", rv_rf, 1);
    end

    // write 120 to addr 3 while reading it, then read again
    drive(1'b1, 4'd3, 8'd120, 1'b1, 4'd3, 1'b0); step();
    chk("async_wr_vis", dout_as, 8'd120);
    chk("rf_old_3", dout_rf, 8'hA5);
    chk("wf_new_3", dout_wf, 8'd120);
    drive(1'b0, '0, '0, 1'b1, 4'd3, 1'b0); step();
    chk("sync_rd3", dout_rf, 8'd120);
    chk("sync_rd3_vld", rv_rf, 1);

    // read-during-write policy at addr 5 (holds 6)
    drive(1'b1, 4'd5, 8'd6, 1'b0, '0, 1'b0); step();
    drive(1'b1, 4'd5, 8'd151, 1'b1, 4'd5, 1'b0); step();
    chk("rdw_read_first", dout_rf, 8'd6);
    chk("rdw_write_first", dout_wf, 8'd151);
    chk("rdw_async", dout_as, 8'd151);

    // clear drops writes; clr mid-clear restarts the sweep
    drive(1'b1, 4'd7, 8'd200, 1'b0, '0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1); step();
    chk("clr_busy", busy_rf, 1);
    drive(1'b1, 4'd7, 8'd99, 1'b1, 4'd7, 1'b0); step();
    chk("busy_rv_rf", rv_rf, 0);
    chk("busy_rv_as", rv_as, 0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0); repeat (3) step();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    wait_clear("clr_len_restart");
    drive(1'b0, '0, '0, 1'b1, 4'd7, 1'b0); step();
    chk("rd7_cleared", dout_rf, 8'hA5);
    chk("rd7_cleared_as", dout_as, 8'hA5);

    // async reset mid-clear at cnt = 9
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b1, 4'd1, 1'b0); repeat (9) step();
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("mid_rst_busy", busy_rf, 1);
    chk("mid_rst_rv", rv_rf, 0);
    chk("mid_rst_dout_rf", dout_rf, 0);
    chk("mid_rst_dout_wf", dout_wf, 0);
    chk("mid_rst_rv_as", rv_as, 0);
    @(negedge clk);
    r_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clr_len_midrst");
    drive(1'b0, '0, '0, 1'b1, 4'd3, 1'b0); step();
    chk("rd3_after_rst", dout_rf, 8'hA5);

    // fill pattern, then overwrite neighbours while reading
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, AW'(a), 8'((a * 37 + 11) & 255), 1'b0, '0, 1'b0); step();
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, AW'((a + 1) % DEPTH), 8'(255 - a), 1'b1, AW'(a), 1'b0); step();
    end
    drive(1'b0, '0, '0, 1'b1, 4'd4, 1'b0); step();
    chk("rd4_pattern", dout_rf, 8'd252);
    drive(1'b0, '0, '0, 1'b1, 4'd0, 1'b0); step();
    chk("rd0_pattern", dout_rf, 8'd240);

`ifdef RAM_PARITY_EN
    // parity error injection and repair
    drive(1'b1, 4'd2, 8'd12, 1'b0, '0, 1'b0); err_inj = 1'b1; step();
    drive(1'b0, '0, '0, 1'b1, 4'd2, 1'b0); step();
    chk("perr_inj_rf", perr_rf, 1);
    chk("perr_inj_as", perr_as, 1);
    chk("perr_inj_vld", rv_rf, 1);
    drive(1'b1, 4'd2, 8'd12, 1'b0, '0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b1, 4'd2, 1'b0); step();
    chk("perr_clean_rf", perr_rf, 0);
    chk("perr_clean_data", dout_rf, 8'd12);
`endif

    drive(1'b0, '0, '0, 1'b0, '0, 1'b0); repeat (2) step();
    chk("rf_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
